// File: rtl/arithmetic_logic_unit.sv
// 8-bit registered ALU: decodes inst[7:4] every rising edge and registers the
// result byte and a Z/C/N/V flag byte. Single stage, one op per cycle.
module arithmetic_logic_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ra,
  input  logic [7:0] rb,
  input  logic [7:0] inst,
  output logic [7:0] rd,
  output logic [7:0] flags
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVA = 4'h1;
  localparam logic [3:0] OP_MOVB = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_ADD  = 4'hA;
  localparam logic [3:0] OP_SUB  = 4'hB;
  localparam logic [3:0] OP_ADC  = 4'hC;
  localparam logic [3:0] OP_SBB  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_SHR  = 4'hF;

  logic [7:0] rd_q, rd_d;
  logic [7:0] flags_q, flags_d;

  logic [3:0] op;
  logic [7:0] add_b, sub_b;
  logic       add_cin, sub_bin;
  logic [8:0] add_sum, sub_diff;
  logic       add_v, sub_v;
  logic [7:0] res;
  logic       c_flag, v_flag;

  always_comb begin
    op       = inst[7:4];
    // INC/DEC reuse the adder/subtractor with a constant +1 operand.
    add_b    = (op == OP_INC) ? 8'h01 : rb;
    add_cin  = (op == OP_ADC) ? flags_q[1] : 1'b0;
    add_sum  = {1'b0, ra} + {1'b0, add_b} + {8'h00, add_cin};
    add_v    = (ra[7] == add_b[7]) && (add_sum[7] != ra[7]);
    sub_b    = (op == OP_DEC) ? 8'h01 : rb;
    sub_bin  = (op == OP_SBB) ? flags_q[1] : 1'b0;
    // Bit 8 of the 9-bit difference is the borrow out.
    sub_diff = {1'b0, ra} - {1'b0, sub_b} - {8'h00, sub_bin};
    sub_v    = (ra[7] != sub_b[7]) && (sub_diff[7] != ra[7]);

    res    = 8'h00;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (op)
      OP_MOVA: res = ra;
      OP_MOVB: res = rb;
      OP_NOT:  res = ~ra;
      OP_AND:  res = ra & rb;
      OP_OR:   res = ra | rb;
      OP_XOR:  res = ra ^ rb;
      OP_INC, OP_ADD, OP_ADC: begin
        res    = add_sum[7:0];
        c_flag = add_sum[8];
        v_flag = add_v;
      end
      OP_CMP, OP_DEC, OP_SUB, OP_SBB: begin
        res    = sub_diff[7:0];
        c_flag = sub_diff[8];
        v_flag = sub_v;
      end
      OP_SHL: begin
        res    = {ra[6:0], 1'b0};
        c_flag = ra[7];
      end
      OP_SHR: begin
        res    = {1'b0, ra[7:1]};
        c_flag = ra[0];
      end
      default: res = 8'h00;
    endcase

    rd_d    = res;
    flags_d = {4'h0, v_flag, res[7], c_flag, (res == 8'h00)};
    if (op == OP_NOP) begin
      rd_d    = rd_q;
      flags_d = flags_q;
    end else if (op == OP_CMP) begin
      rd_d    = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q    <= 8'h00;
      flags_q <= 8'h00;
    end else begin
      rd_q    <= rd_d;
      flags_q <= flags_d;
    end
  end

  assign rd    = rd_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed plus randomized bench for arithmetic_logic_unit; expected {rd,flags}
// words are queued when an instruction is driven and checked after the edge.
module tb_arithmetic_logic_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] ra, rb, inst;
  logic [7:0] rd, flags;

  logic [15:0] exp_q[$];
  int          checks;
  int          errors;
  logic [7:0]  cur_rd, cur_flags;

  arithmetic_logic_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ra    (ra),
    .rb    (rb),
    .inst  (inst),
    .rd    (rd),
    .flags (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: integer arithmetic with signed range checks for V.
  function automatic logic [15:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] prd,
                                        input logic [7:0] pfl);
    int u, s, cin;
    logic [7:0] r;
    logic c, v;
    cin = int'(pfl[1]);
    c = 1'b0;
    v = 1'b0;
    r = 8'h00;
    case (op)
      4'h0: return {prd, pfl};
      4'h1: r = a;
      4'h2: r = b;
      4'h3: r = 8'hFF - a;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h8, 4'hA, 4'hC: begin
        int bb, ci;
        bb = (op == 4'h8) ? 1 : int'(b);
        ci = (op == 4'hC) ? cin : 0;
        u = int'(a) + bb + ci;
        s = int'($signed(a)) + ((op == 4'h8) ? 1 : int'($signed(b))) + ci;
        r = u[7:0];
        c = (u > 255);
        v = (s > 127) || (s < -128);
      end
      4'h7, 4'h9, 4'hB, 4'hD: begin
        int bb, bi;
        bb = (op == 4'h9) ? 1 : int'(b);
        bi = (op == 4'hD) ? cin : 0;
        u = int'(a) - bb - bi;
        s = int'($signed(a)) - ((op == 4'h9) ? 1 : int'($signed(b))) - bi;
        r = u[7:0];
        c = (u < 0);
        v = (s > 127) || (s < -128);
      end
      4'hE: begin r = (a * 2) % 256; c = (a >= 8'h80); end
      default: begin r = a / 2; c = (a % 2 == 1); end
    endcase
    return {(op == 4'h7) ? prd : r, 4'h0, v, r[7], c, (r == 8'h00)};
  endfunction

  task automatic check_out(input string tag);
    logic [15:0] exp, got;
    got = {rd, flags};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: no expected entry queued, got %h", tag, got);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s: rd/flags got %h_%h expected %h_%h", tag, got[15:8], got[7:0],
               exp[15:8], exp[7:0]);
      end
      cur_rd    = exp[15:8];
      cur_flags = exp[7:0];
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp);
    @(negedge clk);
    rst_n = 1'b1;
    inst  = {op, 4'($urandom_range(0, 15))};
    ra    = a;
    rb    = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic reset_step(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    inst  = 8'hA0;
    ra    = 8'hFF;
    rb    = 8'h01;
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cur_rd    = 8'h00;
    cur_flags = 8'h00;
    rst_n     = 1'b0;
    inst      = 8'hA0;
    ra        = 8'hFF;
    rb        = 8'h01;

    for (int i = 0; i < 50; i++) reset_step("reset");
    step("release_add", 4'hA, 8'hFF, 8'h01, 16'h0003);

    step("inc", 4'h8, 8'h7F, 8'h0F, 16'h800C);
    step("dec", 4'h9, 8'h7F, 8'h0F, 16'h7E00);
    step("add", 4'hA, 8'h7F, 8'h0F, 16'h8E0C);
    step("sub", 4'hB, 8'h7F, 8'h0F, 16'h7000);
    step("sub_borrow", 4'hB, 8'h0F, 8'h7F, 16'h9006);
    step("cmp_equal", 4'h7, 8'h55, 8'h55, 16'h9001);

    step("or", 4'h5, 8'h0B, 8'h02, 16'h0B00);
    step("and", 4'h4, 8'h0B, 8'h02, 16'h0200);
    step("xor", 4'h6, 8'h0B, 8'h02, 16'h0900);
    step("not", 4'h3, 8'h0B, 8'h02, 16'hF404);
    step("movb", 4'h2, 8'h0B, 8'h02, 16'h0200);
    step("mova", 4'h1, 8'h80, 8'h02, 16'h8004);

    step("add_carry", 4'hA, 8'hFF, 8'h01, 16'h0003);
    step("adc_chain", 4'hC, 8'h00, 8'h00, 16'h0100);
    step("sbb_set_c", 4'hB, 8'h00, 8'h01, 16'hFF06);
    step("sbb_chain", 4'hD, 8'h10, 8'h00, 16'h0F00);
    step("shl", 4'hE, 8'h81, 8'h00, 16'h0202);
    step("shr", 4'hF, 8'h01, 8'h00, 16'h0003);

    step("pre_hold", 4'hA, 8'h40, 8'h40, 16'h800C);
    for (int i = 0; i < 5; i++)
      step("nop_hold", 4'h0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 16'h800C);
    reset_step("mid_reset");
    step("resume", 4'h8, 8'h00, 8'h00, 16'h0100);

    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      if (i % 8 == 0) a = 8'h7F + 8'(i % 3);
      step("random_op", op, a, b, model(op, a, b, cur_rd, cur_flags));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arithmetic_logic_unit.md
# arithmetic_logic_unit

8-bit registered ALU for the CPU datapath. Each rising clock edge it decodes the opcode nibble of the current instruction byte, combines operands `ra`/`rb`, and registers the 8-bit result and a status-flag byte. It sits between the register file, which supplies `ra`/`rb`, and the write-back/branch logic, which consumes `rd`/`flags`.

## Interface
- No parameters; the datapath is fixed at 8 bits.
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `ra`  input  8  operand A.
- `rb`  input  8  operand B.
- `inst`  input  8  instruction byte; `inst[7:4]` is the opcode, `inst[3:0]` is reserved and ignored.
- `rd`  output  8  registered result.
- `flags`  output  8  registered status: bit0 Z (zero), bit1 C (carry/borrow), bit2 N (`rd[7]`), bit3 V (signed overflow), bits 7:4 always 0.

## Operation
- Opcode map for `inst[7:4]`; all arithmetic is modulo 256:
  - 0000 NOP: `rd` and `flags` hold.
  - 0001 MOVA: `rd = ra`.
  - 0010 MOVB: `rd = rb`.
  - 0011 NOT: `rd = ~ra`.
  - 0100 AND: `rd = ra & rb`.
  - 0101 OR: `rd = ra | rb`.
  - 0110 XOR: `rd = ra ^ rb`.
  - 0111 CMP: flags are computed as for SUB; `rd` holds.
  - 1000 INC: `rd = ra + 1`.
  - 1001 DEC: `rd = ra - 1`.
  - 1010 ADD: `rd = ra + rb`.
  - 1011 SUB: `rd = ra - rb`.
  - 1100 ADC: `rd = ra + rb + C`.
  - 1101 SBB: `rd = ra - rb - C`.
  - 1110 SHL: `rd = {ra[6:0],0}`, C = `ra[7]`.
  - 1111 SHR: `rd = {0,ra[7:1]}`, C = `ra[0]`.
- Z and N always reflect the new result (for CMP, the subtraction result).
- Add class (INC, ADD, ADC):
  - C is the carry out of bit 7.
  - V is set when both operands have the same sign and the result's sign differs. INC uses operand +1.
- Subtract class (DEC, SUB, SBB, CMP):
  - C is the borrow: 1 when the unsigned minuend is less than the subtrahend (plus borrow-in).
  - V is set when the operands have different signs and the result's sign differs from `ra`'s.
- Logic, MOV and NOT ops clear C and V. Shifts clear V.
- ADC/SBB carry-in is the registered `flags[1]` value present before the edge.
- `flags[7:4]` is constant 0.

## Timing
- Fully synchronous with a single register stage. `ra`, `rb` and `inst` are sampled on a rising edge; `rd`/`flags` are valid right after that same edge (latency 1 cycle, throughput 1 op/cycle).
- No handshake. The operation executes on every edge, so a held `inst` re-executes every cycle. With ADC/SBB held, each cycle chains the previous cycle's C.
- Reset: when `rst_n` = 0 at an edge, `rd` = 0x00 and `flags` = 0x00 regardless of `inst`. Reset has priority over any opcode.
- Reset asserted mid-stream clears both registers at that edge. The first edge with `rst_n` = 1 executes normally.
- `rd` and `flags` hold their value between edges, and across NOP. Input changes between edges have no effect until the next edge.

## Test plan
- Reset: `rst_n` = 0 for 50 cycles with ADD, `ra` = 0xFF, `rb` = 0x01 -> `rd` = 0x00, `flags` = 0x00. Release -> next edge gives `rd` = 0x00, `flags` = 0x03.
- `ra` = 0x7F, `rb` = 0x0F, one op per cycle:
  - INC -> 0x80 / 0x0C.
  - DEC -> 0x7E / 0x00.
  - ADD -> 0x8E / 0x0C.
  - SUB -> 0x70 / 0x00.
- Borrow and CMP:
  - `ra` = 0x0F, `rb` = 0x7F, SUB -> 0x90 / 0x06.
  - CMP with `ra` = `rb` = 0x55 -> `rd` unchanged, `flags` = 0x01.
- Logic with `ra` = 0x0B, `rb` = 0x02:
  - OR -> 0x0B / 0x00.
  - AND -> 0x02.
  - XOR -> 0x09.
  - NOT -> 0xF4 / 0x04.
  - MOVB -> 0x02.
- Carry chain and shifts:
  - ADD 0xFF + 0x01 -> 0x00 / 0x03.
  - Then ADC 0x00 + 0x00 -> 0x01 / 0x00.
  - SHL 0x81 -> 0x02 / 0x02.
  - SHR 0x01 -> 0x00 / 0x03.
- Hold: NOP after any op keeps `rd`/`flags` for 5 cycles while `ra`/`rb` toggle. Reset asserted for one edge mid-sequence -> 0x00 / 0x00, then normal resume.
